// File: rtl/execute_stage_if.sv
// Bundles the execute-stage bus: decode-side operands in, and EX/MEM register plus hazard/branch outputs.
// Inputs:  instr_i, pc_plus4_i, rs_data_i, rt_data_i, valid_i.
// Outputs: instr_o, alu_o, wd_o, valid_o, stall_o, branch_taken_o, branch_target_o, md_busy_o.
interface execute_stage_if;
    logic [31:0] instr_i;
    logic [31:0] pc_plus4_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        valid_i;

    logic [31:0] instr_o;
    logic [31:0] alu_o;
    logic [31:0] wd_o;
    logic        valid_o;
    logic        stall_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic        md_busy_o;

    // The execute stage itself.
    modport slave (
        input  instr_i, pc_plus4_i, rs_data_i, rt_data_i, valid_i,
        output instr_o, alu_o, wd_o, valid_o, stall_o,
               branch_taken_o, branch_target_o, md_busy_o
    );

    // Decode stage / memory stage side.
    modport master (
        output instr_i, pc_plus4_i, rs_data_i, rt_data_i, valid_i,
        input  instr_o, alu_o, wd_o, valid_o, stall_o,
               branch_taken_o, branch_target_o, md_busy_o
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU / effective address, beq/bne resolution, store-data forwarding, iterative mult/div with HI/LO.
// Latency: one cycle into the EX/MEM register; mult/div results land in HI/LO MD_CYCLES cycles after issue.
// Backpressure: stall_o (combinational) holds upstream while an mfhi/mflo/mult/div meets a busy unit; a bubble enters EX/MEM.
// Ports: clk, reset (sync, active-high), ex (execute_stage_if.slave) carrying the operand inputs and EX/MEM outputs.
module execute_stage #(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave ex
);
    localparam int CW = $clog2(MD_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rs;
    logic [31:0] rt;

    assign opcode   = ex.instr_i[31:26];
    assign funct    = ex.instr_i[5:0];
    assign shamt    = ex.instr_i[10:6];
    assign imm      = ex.instr_i[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign rs       = ex.rs_data_i;
    assign rt       = ex.rt_data_i;

    // Architectural and working state
    logic [31:0]   instr_q;
    logic [31:0]   alu_q;
    logic [31:0]   wd_q;
    logic          valid_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          md_busy;
    logic [CW-1:0] md_cnt;
    logic          md_is_div;
    logic          md_neg_q;      // negate product / quotient at the end
    logic          md_neg_r;      // negate remainder (dividend was negative)
    logic          md_div0;
    logic [31:0]   md_dividend;   // raw dividend, returned as HI on divide by zero
    logic [31:0]   md_b;          // multiplicand / divisor magnitude
    logic [31:0]   md_acc;        // product high half / partial remainder
    logic [31:0]   md_sh;         // multiplier bits shifting out / quotient bits shifting in

    // Hazard and mult/div issue
    logic is_md_op;
    logic is_mf;
    logic stall;
    logic md_start;
    logic signed_op;

    assign is_md_op  = (opcode == OP_RTYPE) &&
                       ((funct == FN_MULT) || (funct == FN_MULTU) ||
                        (funct == FN_DIV)  || (funct == FN_DIVU));
    assign is_mf     = (opcode == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
    assign stall     = ex.valid_i & md_busy & (is_md_op | is_mf);
    // A mult/div that reaches here unstalled implies the unit is idle.
    assign md_start  = ex.valid_i & is_md_op & ~stall;
    assign signed_op = (funct == FN_MULT) || (funct == FN_DIV);

    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Branch resolution
    logic beq_hit;
    logic bne_hit;

    assign beq_hit            = (opcode == OP_BEQ) && (rs == rt);
    assign bne_hit            = (opcode == OP_BNE) && (rs != rt);
    assign ex.branch_taken_o  = ex.valid_i & (beq_hit | bne_hit);
    assign ex.branch_target_o = ex.pc_plus4_i + {imm_sext[29:0], 2'b00};

    // ALU
    logic [31:0] alu;

    always_comb begin
        alu = 32'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:          alu = rt << shamt;
                    FN_SRL:          alu = rt >> shamt;
                    FN_SRA:          alu = $unsigned($signed(rt) >>> shamt);
                    FN_MFHI:         alu = hi_q;
                    FN_MFLO:         alu = lo_q;
                    FN_ADD, FN_ADDU: alu = rs + rt;
                    FN_SUB, FN_SUBU: alu = rs - rt;
                    FN_AND:          alu = rs & rt;
                    FN_OR:           alu = rs | rt;
                    FN_XOR:          alu = rs ^ rt;
                    FN_NOR:          alu = ~(rs | rt);
                    FN_SLT:          alu = {31'd0, ($signed(rs) < $signed(rt))};
                    FN_SLTU:         alu = {31'd0, (rs < rt)};
                    default:         alu = 32'd0;   // mult/div and unknown functs
                endcase
            end
            OP_ADDI, OP_ADDIU,
            OP_LW, OP_SW:  alu = rs + imm_sext;
            OP_SLTI:       alu = {31'd0, ($signed(rs) < $signed(imm_sext))};
            OP_SLTIU:      alu = {31'd0, (rs < imm_sext)};
            OP_ANDI:       alu = rs & imm_zext;
            OP_ORI:        alu = rs | imm_zext;
            OP_XORI:       alu = rs ^ imm_zext;
            OP_LUI:        alu = {imm, 16'h0000};
            default:       alu = 32'd0;             // branches and unknown opcodes
        endcase
    end

    // One mult/div iteration. Multiply: shift-add with the multiplier retiring
    // out of md_sh's LSB while product bits shift into its MSB. Divide:
    // restoring, dividend bits leave md_sh's MSB and quotient bits enter its LSB.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] acc_nxt;
    logic [31:0] sh_nxt;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        mul_sum   = {1'b0, md_acc} + (md_sh[0] ? {1'b0, md_b} : 33'd0);
        div_shift = {md_acc, md_sh[31]};
        div_diff  = div_shift - {1'b0, md_b};
        acc_nxt   = mul_sum[32:1];
        sh_nxt    = {mul_sum[0], md_sh[31:1]};
        if (md_is_div) begin
            if (!div_diff[32]) begin
                acc_nxt = div_diff[31:0];
                sh_nxt  = {md_sh[30:0], 1'b1};
            end else begin
                acc_nxt = div_shift[31:0];
                sh_nxt  = {md_sh[30:0], 1'b0};
            end
        end
        prod     = {acc_nxt, sh_nxt};
        prod_fix = md_neg_q ? (64'd0 - prod) : prod;
        q_fix    = md_neg_q ? (32'd0 - sh_nxt) : sh_nxt;
        r_fix    = md_neg_r ? (32'd0 - acc_nxt) : acc_nxt;
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (md_is_div) begin
            if (md_div0) begin
                res_hi = md_dividend;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = r_fix;
                res_lo = q_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= 32'd0;
            alu_q       <= 32'd0;
            wd_q        <= 32'd0;
            valid_q     <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            md_busy     <= 1'b0;
            md_cnt      <= '0;
            md_is_div   <= 1'b0;
            md_neg_q    <= 1'b0;
            md_neg_r    <= 1'b0;
            md_div0     <= 1'b0;
            md_dividend <= 32'd0;
            md_b        <= 32'd0;
            md_acc      <= 32'd0;
            md_sh       <= 32'd0;
        end else begin
            // EX/MEM register: bubble on stall or invalid input.
            if (ex.valid_i && !stall) begin
                instr_q <= ex.instr_i;
                alu_q   <= alu;
                wd_q    <= rt;
                valid_q <= 1'b1;
            end else begin
                instr_q <= 32'd0;
                alu_q   <= 32'd0;
                wd_q    <= 32'd0;
                valid_q <= 1'b0;
            end

            if (md_start) begin
                md_busy     <= 1'b1;
                md_cnt      <= '0;
                md_is_div   <= (funct == FN_DIV) || (funct == FN_DIVU);
                md_neg_q    <= signed_op & (rs[31] ^ rt[31]);
                md_neg_r    <= signed_op & rs[31];
                md_div0     <= (rt == 32'd0);
                md_dividend <= rs;
                md_b        <= mag(rt, signed_op);
                md_acc      <= 32'd0;
                md_sh       <= mag(rs, signed_op);
            end else if (md_busy) begin
                md_acc <= acc_nxt;
                md_sh  <= sh_nxt;
                md_cnt <= md_cnt + CW'(1);
                if (md_cnt == CW'(MD_CYCLES - 1)) begin
                    md_busy <= 1'b0;
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                end
            end
        end
    end

    assign ex.instr_o   = instr_q;
    assign ex.alu_o     = alu_q;
    assign ex.wd_o      = wd_q;
    assign ex.valid_o   = valid_q;
    assign ex.stall_o   = stall;
    assign ex.md_busy_o = md_busy;
endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural model.
// Latency: checks EX/MEM one edge after issue; mult/div results checked via mfhi/mflo.
// Backpressure: counts stall_o cycles on mfhi/mflo behind a busy mult/div unit.
module tb_execute_stage;
    logic clk = 1'b0;
    logic reset;

    execute_stage_if ex();

    execute_stage #(.MD_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (ex)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic logic [31:0] r_instr(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd8, 5'd9, 5'd10, sh, fn};
    endfunction

    function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd8, 5'd9, imm};
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return 32'(s);
    endfunction

    // Expected ALU result, straight from the instruction set rules.
    function automatic logic [31:0] exp_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] se;
        logic [31:0] ze;
        int          sa;
        int          sb;
        int          sse;
        op  = ins[31:26];
        fn  = ins[5:0];
        sh  = ins[10:6];
        se  = sext(ins[15:0]);
        ze  = {16'h0000, ins[15:0]};
        sa  = int'(a);
        sb  = int'(b);
        sse = int'(se);
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21) return a + b;
            if (fn == 6'h22 || fn == 6'h23) return a - b;
            if (fn == 6'h24) return a & b;
            if (fn == 6'h25) return a | b;
            if (fn == 6'h26) return a ^ b;
            if (fn == 6'h27) return ~(a | b);
            if (fn == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
            if (fn == 6'h2B) return (a < b) ? 32'd1 : 32'd0;
            if (fn == 6'h00) return b << sh;
            if (fn == 6'h02) return b >> sh;
            if (fn == 6'h03) return 32'(sb >>> sh);
            if (fn == 6'h10) return m_hi;
            if (fn == 6'h12) return m_lo;
            return 32'd0;
        end
        if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) return a + se;
        if (op == 6'h0A) return (sa < sse) ? 32'd1 : 32'd0;
        if (op == 6'h0B) return (a < se) ? 32'd1 : 32'd0;
        if (op == 6'h0C) return a & ze;
        if (op == 6'h0D) return a | ze;
        if (op == 6'h0E) return a ^ ze;
        if (op == 6'h0F) return {ins[15:0], 16'h0000};
        return 32'd0;
    endfunction

    // Expected {HI, LO} of a mult/div.
    function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        int     ia;
        int     ib;
        la = longint'(int'(a));
        lb = longint'(int'(b));
        ia = int'(a);
        ib = int'(b);
        if (fn == 6'h18) return 64'(la * lb);
        if (fn == 6'h19) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (fn == 6'h1A) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(ia % ib), 32'(ia / ib)};
        end
        return {a % b, a / b};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        ex.instr_i    = ins;
        ex.pc_plus4_i = pc;
        ex.rs_data_i  = a;
        ex.rt_data_i  = b;
        ex.valid_i    = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, $urandom, $urandom, $urandom, 1'b1);
            tick();
        end
        checks++;
        if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o, ex.md_busy_o, ex.stall_o} !== 99'd0) begin
            errors++;
            $display("FAIL reset_state: instr=%h alu=%h wd=%h valid=%b busy=%b stall=%b, required all zero",
                     ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o, ex.md_busy_o, ex.stall_o);
        end
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        ins = r_instr(6'h21, 5'd0);
        drive(ins, 32'h0000_0004, 32'd5, 32'd7, 1'b1);
        tick();
        checks++;
        if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o} !== {ins, 32'd12, 32'd7, 1'b1}) begin
            errors++;
            $display("FAIL first_addu: instr=%h alu=%h wd=%h valid=%b, required %h %h %h 1",
                     ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o, ins, 32'd12, 32'd7);
        end
    endtask

    task automatic test_store_branch();
        logic [31:0] ins;
        ins = i_instr(6'h2B, 16'hFFFC);
        drive(ins, 32'h0000_0010, 32'h0000_1000, 32'h0000_DEAD, 1'b1);
        tick();
        checks++;
        if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o} !== {ins, 32'h0000_0FFC, 32'h0000_DEAD, 1'b1}) begin
            errors++;
            $display("FAIL sw_addr: instr=%h alu=%h wd=%h valid=%b, required %h 00000ffc 0000dead 1",
                     ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o, ins);
        end
        drive(i_instr(6'h04, 16'h0002), 32'h0000_0040, 32'd3, 32'd3, 1'b1);
        #1;
        checks++;
        if ({ex.branch_taken_o, ex.branch_target_o} !== {1'b1, 32'h0000_0048}) begin
            errors++;
            $display("FAIL beq_taken: taken=%b target=%h, required 1 00000048", ex.branch_taken_o, ex.branch_target_o);
        end
        tick();
        drive(i_instr(6'h05, 16'h0002), 32'h0000_0040, 32'd3, 32'd3, 1'b1);
        #1;
        checks++;
        if ({ex.branch_taken_o, ex.branch_target_o} !== {1'b0, 32'h0000_0048}) begin
            errors++;
            $display("FAIL bne_equal: taken=%b target=%h, required 0 00000048", ex.branch_taken_o, ex.branch_target_o);
        end
        tick();
        drive(i_instr(6'h05, 16'hFFFF), 32'h0000_0100, 32'd3, 32'd4, 1'b1);
        #1;
        checks++;
        if ({ex.branch_taken_o, ex.branch_target_o} !== {1'b1, 32'h0000_00FC}) begin
            errors++;
            $display("FAIL bne_back: taken=%b target=%h, required 1 000000fc", ex.branch_taken_o, ex.branch_target_o);
        end
        drive(i_instr(6'h04, 16'h0001), 32'h0000_0100, 32'd3, 32'd3, 1'b0);
        #1;
        checks++;
        if (ex.branch_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL beq_bubble: taken=%b, required 0", ex.branch_taken_o);
        end
        tick();
    endtask

    task automatic test_alu_random();
        logic [11:0] tbl [29] = '{
            {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
            {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B},
            {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h00, 6'h10}, {6'h00, 6'h12},
            {6'h00, 6'h3F}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0A, 6'h00}, {6'h0B, 6'h00},
            {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0E, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
            {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h3F, 6'h00}};
        logic [11:0] e;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic        v;
        logic        tk;
        logic [31:0] tg;
        for (int i = 0; i < 80; i++) begin
            e  = tbl[$urandom_range(0, 28)];
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom)};
            pc = $urandom & 32'hFFFF_FFFC;
            v  = ($urandom_range(0, 7) != 0);
            if (e[11:6] == 6'h00)
                ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), e[5:0]};
            else
                ins = {e[11:6], 5'($urandom), 5'($urandom), 16'($urandom)};
            drive(ins, pc, a, b, v);
            #1;
            tk = v && (((e[11:6] == 6'h04) && (a == b)) || ((e[11:6] == 6'h05) && (a != b)));
            tg = pc + sext(ins[15:0]) * 32'd4;
            checks++;
            if ({ex.branch_taken_o, ex.branch_target_o, ex.stall_o} !== {tk, tg, 1'b0}) begin
                errors++;
                $display("FAIL alu_rand_branch[%0d]: taken=%b target=%h stall=%b, required %b %h 0 (instr %h)",
                         i, ex.branch_taken_o, ex.branch_target_o, ex.stall_o, tk, tg, ins);
            end
            tick();
            checks++;
            if (v) begin
                if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o} !== {ins, exp_alu(ins, a, b), b, 1'b1}) begin
                    errors++;
                    $display("FAIL alu_rand[%0d]: instr=%h alu=%h wd=%h valid=%b, required %h %h %h 1 (rs %h rt %h)",
                             i, ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o, ins, exp_alu(ins, a, b), b, a, b);
                end
            end else if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o} !== 97'd0) begin
                errors++;
                $display("FAIL alu_rand_bubble[%0d]: instr=%h alu=%h wd=%h valid=%b, required zeros",
                         i, ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o);
            end
        end
    endtask

    task automatic test_mult_stall();
        logic [31:0] ins;
        int n;
        ins = r_instr(6'h18, 5'd0);
        drive(ins, 32'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        tick();
        checks++;
        if ({ex.instr_o, ex.alu_o, ex.valid_o, ex.md_busy_o} !== {ins, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mult_issue: instr=%h alu=%h valid=%b busy=%b, required %h 0 1 1",
                     ex.instr_o, ex.alu_o, ex.valid_o, ex.md_busy_o, ins);
        end
        ins = r_instr(6'h12, 5'd0);
        drive(ins, 32'd0, 32'd0, 32'd0, 1'b1);
        #1;
        n = 0;
        while (ex.stall_o === 1'b1 && n < 40) begin
            tick();
            n++;
            checks++;
            if ({ex.instr_o, ex.alu_o, ex.wd_o, ex.valid_o} !== 97'd0) begin
                errors++;
                $display("FAIL mult_stall_bubble[%0d]: instr=%h alu=%h valid=%b, required zeros",
                         n, ex.instr_o, ex.alu_o, ex.valid_o);
            end
        end
        checks++;
        if (n !== 32 || ex.md_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mult_stall_len: stalled %0d cycles busy=%b, required 32 cycles busy=0", n, ex.md_busy_o);
        end
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;
        tick();
        checks++;
        if ({ex.instr_o, ex.alu_o, ex.valid_o} !== {ins, 32'hFFFF_FFEB, 1'b1}) begin
            errors++;
            $display("FAIL mult_mflo: instr=%h alu=%h valid=%b, required %h ffffffeb 1", ex.instr_o, ex.alu_o, ex.valid_o, ins);
        end
        drive(r_instr(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checks++;
        if (ex.alu_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mult_mfhi: alu=%h, required ffffffff", ex.alu_o);
        end
    endtask

    task automatic test_divu_overlap();
        drive(r_instr(6'h1B, 5'd0), 32'd0, 32'd100, 32'd7, 1'b1);
        tick();
        drive(r_instr(6'h21, 5'd0), 32'd0, 32'd1, 32'd2, 1'b1);
        #1;
        checks++;
        if (ex.stall_o !== 1'b0 || ex.md_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL divu_addu_stall: stall=%b busy=%b, required 0 1", ex.stall_o, ex.md_busy_o);
        end
        tick();
        checks++;
        if ({ex.alu_o, ex.valid_o} !== {32'd3, 1'b1}) begin
            errors++;
            $display("FAIL divu_addu_result: alu=%h valid=%b, required 00000003 1", ex.alu_o, ex.valid_o);
        end
        for (int i = 0; i < 38; i++) begin
            drive($urandom, 32'd0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        m_hi = 32'd2;
        m_lo = 32'd14;
        drive(r_instr(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checks++;
        if ({ex.alu_o, ex.md_busy_o} !== {32'd14, 1'b0}) begin
            errors++;
            $display("FAIL divu_mflo: alu=%h busy=%b, required 0000000e 0", ex.alu_o, ex.md_busy_o);
        end
        drive(r_instr(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checks++;
        if (ex.alu_o !== 32'd2) begin
            errors++;
            $display("FAIL divu_mfhi: alu=%h, required 00000002", ex.alu_o);
        end
    endtask

    task automatic test_muldiv();
        logic [5:0]  fns [6] = '{6'h1A, 6'h1A, 6'h1A, 6'h1B, 6'h19, 6'h18};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'd9, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] r;
        int gap;
        int n;
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                fn = fns[i];
                a  = as[i];
                b  = bs[i];
                gap = 0;
            end else begin
                fn = 6'h18 + 6'($urandom_range(0, 3));
                a  = $urandom;
                b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
                gap = $urandom_range(0, 4);
            end
            r = md_model(fn, a, b);
            drive(r_instr(fn, 5'd0), 32'd0, a, b, 1'b1);
            #1;
            checks++;
            if (ex.stall_o !== 1'b0) begin
                errors++;
                $display("FAIL md_issue_stall[%0d]: stall=%b, required 0", i, ex.stall_o);
            end
            tick();
            for (int g = 0; g < gap; g++) begin
                x = $urandom;
                y = $urandom;
                drive(r_instr(6'h21, 5'd0), 32'd0, x, y, 1'b1);
                tick();
                checks++;
                if ({ex.alu_o, ex.valid_o} !== {x + y, 1'b1}) begin
                    errors++;
                    $display("FAIL md_overlap[%0d]: alu=%h valid=%b, required %h 1", i, ex.alu_o, ex.valid_o, x + y);
                end
            end
            drive(r_instr(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
            #1;
            n = 0;
            while (ex.stall_o === 1'b1 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 32 - gap) begin
                errors++;
                $display("FAIL md_stall_len[%0d]: stalled %0d cycles, required %0d", i, n, 32 - gap);
            end
            m_hi = r[63:32];
            m_lo = r[31:0];
            tick();
            checks++;
            if (ex.alu_o !== r[31:0]) begin
                errors++;
                $display("FAIL md_lo[%0d]: fn=%h a=%h b=%h lo=%h, required %h", i, fn, a, b, ex.alu_o, r[31:0]);
            end
            drive(r_instr(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
            tick();
            checks++;
            if (ex.alu_o !== r[63:32]) begin
                errors++;
                $display("FAIL md_hi[%0d]: fn=%h a=%h b=%h hi=%h, required %h", i, fn, a, b, ex.alu_o, r[63:32]);
            end
        end
    endtask

    task automatic test_reset_abort();
        drive(r_instr(6'h18, 5'd0), 32'd0, 32'h1234_5678, 32'h0BAD_F00D, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        checks++;
        if (ex.md_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_inflight: busy=%b, required 1", ex.md_busy_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (ex.md_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b, required 0", ex.md_busy_o);
        end
        drive(r_instr(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checks++;
        if (ex.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_mfhi_stall: stall=%b, required 0", ex.stall_o);
        end
        tick();
        checks++;
        if ({ex.alu_o, ex.valid_o} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_mfhi: alu=%h valid=%b, required 00000000 1", ex.alu_o, ex.valid_o);
        end
        for (int i = 0; i < 30; i++) begin
            drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
            tick();
        end
        drive(r_instr(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        checks++;
        if ({ex.alu_o, ex.valid_o} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_mflo_late: alu=%h valid=%b, required 00000000 1", ex.alu_o, ex.valid_o);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_store_branch();
        test_alu_random();
        test_mult_stall();
        test_divu_overlap();
        test_muldiv();
        test_alu_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between decode and memory_stage.
- Computes the ALU result / effective address, resolves beq/bne, and forwards store data.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Outputs are the registered EX/MEM pipeline register that drives memory_stage (instr, addr, write data).

Parameters:
- MD_CYCLES, 32, iterations of the mult/div unit (one result bit per cycle).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_i  input  32  instruction currently in EX.
- pc_plus4_i  input  32  PC+4 of instr_i.
- rs_data_i  input  32  rs operand, already forwarded upstream.
- rt_data_i  input  32  rt operand, already forwarded upstream.
- valid_i  input  1  instr_i is a real instruction, not a bubble.
- instr_o  output  32  EX/MEM instruction, feeds memory_stage instr_i.
- alu_o  output  32  EX/MEM ALU result / address, feeds memory_stage addr_i.
- wd_o  output  32  EX/MEM store data (rt_data_i), feeds memory_stage wd_i.
- valid_o  output  1  EX/MEM valid.
- stall_o  output  1  combinational. Upstream must hold IF/ID/EX contents this cycle.
- branch_taken_o  output  1  combinational. Taken beq/bne in EX.
- branch_target_o  output  32  combinational. pc_plus4_i + (sign-extended imm << 2).
- md_busy_o  output  1  mult/div iteration in progress.

Behaviour:
- Reset (synchronous): instr_o=0, alu_o=0, wd_o=0, valid_o=0, HI=0, LO=0, md_busy_o=0, iteration counter=0. Reset aborts any mult/div in flight, with no result written.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, mult, multu, div, divu, mfhi, mflo.
  - I-type: addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
  - Unknown opcode/funct: alu_o=0, still passed through.
- Arithmetic rules:
  - add/sub/addi wrap with no overflow trap.
  - andi/ori/xori zero-extend imm. addi/addiu/slti/sltiu/lw/sw/branches sign-extend imm.
  - sltiu compares unsigned against the sign-extended imm.
  - lui: alu_o = {imm,16'h0}.
  - Shifts use shamt = instr[10:6] on rt.
  - lw/sw: alu_o = rs + sext(imm).
  - mfhi/mflo: alu_o = HI/LO.
  - mult/div: alu_o = 0.
- Branches: branch_taken_o = valid_i & ((beq & rs==rt) | (bne & rs!=rt)), evaluated every cycle, including during a stall. Upstream ignores it while stall_o=1.
- Latency: one cycle. Values presented in cycle N appear on the *_o outputs after edge N+1.
- Stall rules:
  - stall_o = valid_i & md_busy_o & (instr_i is mfhi, mflo, mult, multu, div or divu).
  - While stalled, the EX/MEM register loads a bubble: instr_o=0, alu_o=0, wd_o=0, valid_o=0. instr_i is not consumed.
  - Non-muldiv instructions never stall and proceed while the unit is busy.
- Mult/div start:
  - A valid, unstalled mult/multu/div/divu in EX at cycle N latches its operands.
  - md_busy_o is high for cycles N+1..N+MD_CYCLES.
  - HI/LO are written on the edge ending cycle N+MD_CYCLES; md_busy_o falls in the same edge.
  - mfhi/mflo in EX at cycle N+MD_CYCLES+1 or later proceed. Earlier ones stall.
  - The starting instruction itself passes to EX/MEM as a non-writing instruction.
- Multiply: shift-add on magnitudes. Signed: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
- Divide: restoring division on magnitudes. Quotient truncates toward zero; remainder takes the dividend's sign. LO = quotient, HI = remainder.
- Divide boundaries:
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend. Still takes MD_CYCLES.
  - div 0x8000_0000 / -1: LO = 0x8000_0000, HI = 0.
- valid_i=0: treated as a bubble. Nothing starts, no stall, outputs load the bubble.

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0, md_busy_o=0. Then addu with rs=5, rt=7 -> after one edge, alu_o=12, instr_o=instr, valid_o=1.
- sw with rs=0x1000, imm=0xFFFC, rt=0xDEAD -> alu_o=0x0FFC, wd_o=0xDEAD. beq with rs=rt=3, pc_plus4=0x40, imm=2 -> branch_taken_o=1, branch_target_o=0x48. bne on the same operands -> branch_taken_o=0.
- mult with rs=-3, rt=7, then mflo immediately -> stall_o=1 for 32 cycles with bubbles on the outputs, then alu_o=0xFFFF_FFEB. A following mfhi -> 0xFFFF_FFFF.
- divu with rs=100, rt=7, followed by an addu -> addu not stalled. mflo 40 cycles later -> 14; mfhi -> 2.
- div with rs=-7, rt=2 -> LO=-3, HI=-1. div by zero with rs=9 -> LO=0xFFFF_FFFF, HI=9.
- mult started, reset pulsed mid-iteration (cycle 10) -> md_busy_o=0, HI=LO=0. A subsequent mfhi does not stall and returns 0.
